// File: rtl/maze_grid.sv
// Maze cell state for dots and power pellets: row-by-row level load, registered eat handshake,
// incremental item counter, blink timer and one-cycle-latency render pixel flags.
module maze_grid #(
  parameter int MAZE_W       = 20,
  parameter int MAZE_H       = 15,
  parameter int CELL_SIZE    = 10,
  parameter int XW           = 5,
  parameter int YW           = 4,
  parameter int PXW          = 8,
  parameter int CNT_W        = 9,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      game_reset,
  input  logic [MAZE_W*MAZE_H-1:0]  wall_map,
  input  logic [MAZE_W*MAZE_H-1:0]  pellet_map,
  output logic                      ready,
  input  logic [XW-1:0]             query_x,
  input  logic [YW-1:0]             query_y,
  output logic                      is_wall,
  output logic                      has_dot,
  output logic                      has_pellet,
  input  logic                      eat_req,
  input  logic [XW-1:0]             eat_x,
  input  logic [YW-1:0]             eat_y,
  output logic                      eat_ack,
  output logic [1:0]                eat_type,
  input  logic                      frame_tick,
  input  logic [PXW-1:0]            pixel_x,
  input  logic [PXW-1:0]            pixel_y,
  output logic                      render_wall,
  output logic                      render_dot,
  output logic                      render_pellet,
  output logic [CNT_W-1:0]          dots_remaining,
  output logic                      all_dots_eaten,
  output logic                      level_clear
);

  localparam int N  = MAZE_W * MAZE_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (MAZE_H > 1) ? $clog2(MAZE_H) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [N-1:0]     dot_q, dot_d, pel_q, pel_d;
  logic [CNT_W-1:0] count_q, count_d, row_items;
  logic             eat_ack_q, eat_ack_d, level_clear_q, level_clear_d;
  logic [1:0]       eat_type_q, eat_type_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             render_wall_q, render_wall_d, render_dot_q, render_dot_d;
  logic             render_pellet_q, render_pellet_d;
  logic             eat_in_range, q_in_range, r_in_range, dot_area, pel_area;
  logic [IW-1:0]    eat_idx, q_idx, r_idx, load_idx;
  logic [PXW-1:0]   px_cell, py_cell, px_off, py_off;

  function automatic logic [IW-1:0] cell_idx(input int x, input int y);
    return IW'(y * MAZE_W + x);
  endfunction

  // Level load, eat handling and blink timer next-state
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    dot_d         = dot_q;
    pel_d         = pel_q;
    count_d       = count_q;
    eat_ack_d     = eat_req;
    eat_type_d    = 2'b00;
    level_clear_d = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    row_items     = '0;
    load_idx      = '0;
    eat_in_range  = (int'(eat_x) < MAZE_W) && (int'(eat_y) < MAZE_H);
    eat_idx       = cell_idx(int'(eat_x), int'(eat_y));
    case (state_q)
      S_INIT: begin
        for (int x = 0; x < MAZE_W; x++) begin
          load_idx        = cell_idx(x, int'(row_q));
          dot_d[load_idx] = ~wall_map[load_idx] & ~pellet_map[load_idx];
          pel_d[load_idx] = pellet_map[load_idx] & ~wall_map[load_idx];
          row_items       = row_items + {{(CNT_W-1){1'b0}}, ~wall_map[load_idx]};
        end
        count_d = count_q + row_items;
        if (row_q == RW'(MAZE_H - 1)) begin
          state_d = S_RUN;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      S_RUN: begin
        if (eat_req && eat_in_range && dot_q[eat_idx]) begin
          dot_d[eat_idx] = 1'b0;
          eat_type_d     = 2'b01;
          count_d        = count_q - CNT_W'(1);
          level_clear_d  = (count_q == CNT_W'(1));
        end else if (eat_req && eat_in_range && pel_q[eat_idx]) begin
          pel_d[eat_idx] = 1'b0;
          eat_type_d     = 2'b10;
          count_d        = count_q - CNT_W'(1);
          level_clear_d  = (count_q == CNT_W'(1));
        end else begin
          eat_type_d = 2'b00;
        end
        if (frame_tick && (blink_cnt_q == BW'(BLINK_FRAMES - 1))) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else if (frame_tick) begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end else begin
          blink_cnt_d = blink_cnt_q;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Combinational cell query; items are hidden until the level is fully loaded
  always_comb begin
    q_in_range = (int'(query_x) < MAZE_W) && (int'(query_y) < MAZE_H);
    q_idx      = cell_idx(int'(query_x), int'(query_y));
    if (q_in_range) begin
      is_wall    = wall_map[q_idx];
      has_dot    = (state_q == S_RUN) && dot_q[q_idx];
      has_pellet = (state_q == S_RUN) && pel_q[q_idx];
    end else begin
      is_wall    = 1'b1;
      has_dot    = 1'b0;
      has_pellet = 1'b0;
    end
  end

  // Render pixel classification ahead of the output register
  always_comb begin
    px_cell    = pixel_x / PXW'(CELL_SIZE);
    py_cell    = pixel_y / PXW'(CELL_SIZE);
    px_off     = pixel_x % PXW'(CELL_SIZE);
    py_off     = pixel_y % PXW'(CELL_SIZE);
    r_in_range = (int'(px_cell) < MAZE_W) && (int'(py_cell) < MAZE_H);
    r_idx      = cell_idx(int'(px_cell), int'(py_cell));
    dot_area   = (px_off >= PXW'(CELL_SIZE/2 - 1)) && (px_off <= PXW'(CELL_SIZE/2)) &&
                 (py_off >= PXW'(CELL_SIZE/2 - 1)) && (py_off <= PXW'(CELL_SIZE/2));
    pel_area   = (px_off >= PXW'(CELL_SIZE/2 - 2)) && (px_off <= PXW'(CELL_SIZE/2 + 1)) &&
                 (py_off >= PXW'(CELL_SIZE/2 - 2)) && (py_off <= PXW'(CELL_SIZE/2 + 1));
    if (r_in_range) begin
      render_wall_d   = wall_map[r_idx];
      render_dot_d    = ~wall_map[r_idx] & dot_q[r_idx] & dot_area;
      render_pellet_d = ~wall_map[r_idx] & pel_q[r_idx] & pel_area & ~blink_phase_q;
    end else begin
      render_wall_d   = 1'b0;
      render_dot_d    = 1'b0;
      render_pellet_d = 1'b0;
    end
  end

  // State registers; either reset source restarts the level load
  always_ff @(posedge clk) begin
    if (rst || game_reset) begin
      state_q         <= S_INIT;
      row_q           <= '0;
      dot_q           <= '0;
      pel_q           <= '0;
      count_q         <= '0;
      eat_ack_q       <= 1'b0;
      eat_type_q      <= 2'b00;
      level_clear_q   <= 1'b0;
      blink_cnt_q     <= '0;
      blink_phase_q   <= 1'b0;
      render_wall_q   <= 1'b0;
      render_dot_q    <= 1'b0;
      render_pellet_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      dot_q           <= dot_d;
      pel_q           <= pel_d;
      count_q         <= count_d;
      eat_ack_q       <= eat_ack_d;
      eat_type_q      <= eat_type_d;
      level_clear_q   <= level_clear_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_phase_q   <= blink_phase_d;
      render_wall_q   <= render_wall_d;
      render_dot_q    <= render_dot_d;
      render_pellet_q <= render_pellet_d;
    end
  end

  assign ready          = (state_q == S_RUN);
  assign eat_ack        = eat_ack_q;
  assign eat_type       = eat_type_q;
  assign level_clear    = level_clear_q;
  assign dots_remaining = count_q;
  assign all_dots_eaten = (state_q == S_RUN) && (count_q == '0);
  assign render_wall    = render_wall_q;
  assign render_dot     = render_dot_q;
  assign render_pellet  = render_pellet_q;

endmodule

// File: tb/tb_maze_grid.sv
// Randomised and directed bench for maze_grid against a cell-array model of the maze rules.
module tb_maze_grid;

  localparam int W = 20, H = 15, CS = 10, BF = 16, N = W * H;

  logic           clk = 1'b0;
  logic           rst, game_reset, eat_req, frame_tick;
  logic [N-1:0]   wall_map, pellet_map;
  logic [4:0]     query_x, eat_x;
  logic [3:0]     query_y, eat_y;
  logic [7:0]     pixel_x, pixel_y;
  logic           ready, is_wall, has_dot, has_pellet, eat_ack, level_clear, all_dots_eaten;
  logic [1:0]     eat_type;
  logic           render_wall, render_dot, render_pellet;
  logic [8:0]     dots_remaining;

  always #5 clk = ~clk;

  maze_grid dut (
    .clk(clk), .rst(rst), .game_reset(game_reset), .wall_map(wall_map), .pellet_map(pellet_map),
    .ready(ready), .query_x(query_x), .query_y(query_y), .is_wall(is_wall), .has_dot(has_dot),
    .has_pellet(has_pellet), .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y), .eat_ack(eat_ack),
    .eat_type(eat_type), .frame_tick(frame_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .render_wall(render_wall), .render_dot(render_dot), .render_pellet(render_pellet),
    .dots_remaining(dots_remaining), .all_dots_eaten(all_dots_eaten), .level_clear(level_clear)
  );

  // Reference model: per-cell item flags plus level/blink status
  bit m_dot [N];
  bit m_pel [N];
  bit m_run, m_phase;
  int m_loaded, m_count, m_bc;
  int checks = 0, errors = 0;
  int full, n, lc_pulses;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_phase = 1'b0; m_loaded = 0; m_count = 0; m_bc = 0;
    for (int i = 0; i < N; i++) begin m_dot[i] = 1'b0; m_pel[i] = 1'b0; end
  endtask

  // One clock: predict from the model, advance it, then compare every output
  task automatic step();
    bit e_rw, e_rd, e_rp, e_ack, e_lc, e_w, e_d, e_p;
    logic [1:0] e_type;
    int cx, cy, ox, oy, i;
    cx = pixel_x / CS; cy = pixel_y / CS; ox = pixel_x % CS; oy = pixel_y % CS;
    e_rw = 0; e_rd = 0; e_rp = 0; e_ack = 0; e_lc = 0; e_type = 2'b00;
    if (cx < W && cy < H) begin
      i = cy * W + cx;
      e_rw = wall_map[i];
      e_rd = !wall_map[i] && m_dot[i] && ox >= 4 && ox <= 5 && oy >= 4 && oy <= 5;
      e_rp = !wall_map[i] && m_pel[i] && ox >= 3 && ox <= 6 && oy >= 3 && oy <= 6 && !m_phase;
    end
    if (rst || game_reset) begin
      model_reset();
      e_rw = 0; e_rd = 0; e_rp = 0;
    end else if (m_run) begin
      e_ack = eat_req;
      if (eat_req && eat_x < W && eat_y < H) begin
        i = eat_y * W + eat_x;
        if (m_dot[i]) begin m_dot[i] = 0; e_type = 2'b01; m_count--; e_lc = (m_count == 0); end
        else if (m_pel[i]) begin m_pel[i] = 0; e_type = 2'b10; m_count--; e_lc = (m_count == 0); end
      end
      if (frame_tick) begin
        m_bc++;
        if (m_bc == BF) begin m_bc = 0; m_phase = !m_phase; end
      end
    end else begin
      e_ack = eat_req;
      for (int x = 0; x < W; x++) begin
        i = m_loaded * W + x;
        m_dot[i] = !wall_map[i] && !pellet_map[i];
        m_pel[i] = pellet_map[i] && !wall_map[i];
        if (!wall_map[i]) m_count++;
      end
      m_loaded++;
      if (m_loaded == H) m_run = 1'b1;
    end
    @(posedge clk); #1;
    e_w = 1; e_d = 0; e_p = 0;
    if (query_x < W && query_y < H) begin
      i = query_y * W + query_x;
      e_w = wall_map[i]; e_d = m_run && m_dot[i]; e_p = m_run && m_pel[i];
    end
    check_eq("ready", 32'(ready), 32'(m_run));
    check_eq("eat_ack", 32'(eat_ack), 32'(e_ack));
    check_eq("eat_type", 32'(eat_type), 32'(e_type));
    check_eq("level_clear", 32'(level_clear), 32'(e_lc));
    check_eq("dots_remaining", 32'(dots_remaining), 32'(m_count));
    check_eq("all_dots_eaten", 32'(all_dots_eaten), 32'(m_run && m_count == 0));
    check_eq("render_wall", 32'(render_wall), 32'(e_rw));
    check_eq("render_dot", 32'(render_dot), 32'(e_rd));
    check_eq("render_pellet", 32'(render_pellet), 32'(e_rp));
    check_eq("is_wall", 32'(is_wall), 32'(e_w));
    check_eq("has_dot", 32'(has_dot), 32'(e_d));
    check_eq("has_pellet", 32'(has_pellet), 32'(e_p));
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < 100) begin step(); n++; end
    check_eq(tag, 32'(n), 32'(H));
  endtask

  initial begin
    rst = 1; game_reset = 0; eat_req = 0; frame_tick = 0;
    eat_x = '0; eat_y = '0; query_x = 5'd1; query_y = 4'd1; pixel_x = 8'd14; pixel_y = 8'd14;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        wall_map[y*W+x] = (x == 0 || x == W-1 || y == 0 || y == H-1 || (x % 2 == 0 && y % 2 == 0));
    pellet_map = '0;
    pellet_map[13*W+1] = 1'b1; pellet_map[1*W+18] = 1'b1; pellet_map[13*W+18] = 1'b1;
    pellet_map[7*W+9]  = 1'b1; pellet_map[1*W+5]  = 1'b1;
    full = 0;
    for (int i = 0; i < N; i++) if (!wall_map[i]) full++;
    model_reset();

    step(); step();
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_count", 32'(dots_remaining), 32'd0);
    check_eq("rst_ack", 32'(eat_ack), 32'd0);
    check_eq("rst_all_eaten", 32'(all_dots_eaten), 32'd0);
    check_eq("rst_render_dot", 32'(render_dot), 32'd0);

    rst = 0;
    eat_req = 1; eat_x = 5'd1; eat_y = 4'd1;
    step();
    check_eq("init_eat_type", 32'(eat_type), 32'd0);
    check_eq("init_has_dot", 32'(has_dot), 32'd0);
    eat_req = 0;
    n = 1;
    while (!ready && n < 100) begin step(); n++; end
    check_eq("init_latency", 32'(n), 32'(H));
    check_eq("init_count", 32'(dots_remaining), 32'(full));

    eat_req = 1; eat_x = 5'd1; eat_y = 4'd1; query_x = 5'd1; query_y = 4'd1;
    step();
    check_eq("eat11_type", 32'(eat_type), 32'd1);
    check_eq("eat11_count", 32'(dots_remaining), 32'(full - 1));
    check_eq("eat11_has_dot", 32'(has_dot), 32'd0);
    step();
    check_eq("eat11_again", 32'(eat_type), 32'd0);
    eat_x = 5'd18; eat_y = 4'd1; step();
    check_eq("eat_pellet", 32'(eat_type), 32'd2);
    eat_x = 5'd0;  eat_y = 4'd0; step();
    check_eq("eat_wall", 32'(eat_type), 32'd0);
    eat_x = 5'd25; eat_y = 4'd3; step();
    check_eq("eat_oor", 32'(eat_type), 32'd0);
    check_eq("eat_seq_count", 32'(dots_remaining), 32'(full - 2));

    for (int c = 0; c < 400; c++) begin
      eat_req    = 1'($urandom_range(0, 1));
      eat_x      = 5'($urandom_range(0, 23));
      eat_y      = 4'($urandom_range(0, 15));
      query_x    = 5'($urandom_range(0, 31));
      query_y    = 4'($urandom_range(0, 15));
      pixel_x    = 8'($urandom_range(0, 219));
      pixel_y    = 8'($urandom_range(0, 159));
      frame_tick = ($urandom_range(0, 3) == 0);
      game_reset = ($urandom_range(0, 149) == 0);
      step();
    end
    game_reset = 0; frame_tick = 0; eat_req = 0;
    n = 0;
    while (!ready && n < 100) begin step(); n++; end

    lc_pulses = 0;
    eat_req = 1;
    for (int i = 0; i < N; i++) begin
      if (m_dot[i] || m_pel[i]) begin
        eat_x = 5'(i % W); eat_y = 4'(i / W);
        step();
        if (level_clear) lc_pulses++;
      end
    end
    check_eq("clear_final_pulse", 32'(level_clear), 32'd1);
    check_eq("clear_all_eaten", 32'(all_dots_eaten), 32'd1);
    eat_x = 5'd3; eat_y = 4'd1; step();
    if (level_clear) lc_pulses++;
    check_eq("clear_pulses", 32'(lc_pulses), 32'd1);
    check_eq("clear_still_eaten", 32'(all_dots_eaten), 32'd1);

    game_reset = 1; eat_req = 1; eat_x = 5'd1; eat_y = 4'd1;
    step();
    check_eq("greset_ack", 32'(eat_ack), 32'd0);
    check_eq("greset_ready", 32'(ready), 32'd0);
    game_reset = 0; eat_req = 0;
    wait_ready("greset_latency");
    check_eq("greset_count", 32'(dots_remaining), 32'(full));

    query_x = 5'd9; query_y = 4'd7;
    for (int t = 0; t < 32; t++) begin
      frame_tick = 1; step(); frame_tick = 0;
      for (int o = 3; o <= 6; o++) begin
        pixel_x = 8'(90 + o); pixel_y = 8'd74;
        step();
        check_eq("blink_pellet", 32'(render_pellet), 32'((((t + 1) / BF) % 2) == 0));
      end
    end

    wall_map = '1; pellet_map = '1; game_reset = 1;
    step();
    game_reset = 0;
    wait_ready("empty_latency");
    check_eq("empty_all_eaten", 32'(all_dots_eaten), 32'd1);
    check_eq("empty_no_clear", 32'(level_clear), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_grid.md
# maze_grid

Parametrised successor to the fixed 20x15 maze. It holds the dot and power-pellet state for a level-loadable maze of MAZE_W x MAZE_H cells. Wall and pellet layouts arrive as flat bitmaps from the level ROM and are loaded into state row by row after reset. The block keeps an incremental remaining-item counter and answers eat requests with a registered handshake. It feeds the renderer with one-cycle-latency wall, dot and blinking-pellet pixels.

## Interface
- MAZE_W, 20, cells per row
- MAZE_H, 15, rows
- CELL_SIZE, 10, pixels per cell side (>= 8)
- XW, 5, cell x coordinate width
- YW, 4, cell y coordinate width
- PXW, 8, pixel coordinate width
- CNT_W, 9, item counter width; must hold MAZE_W*MAZE_H
- BLINK_FRAMES, 16, frame_tick pulses per pellet blink half-period

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- game_reset  in  1  synchronous level reload; same effect as rst on maze state
- wall_map  in  MAZE_W*MAZE_H  1 = wall; bit y*MAZE_W+x is cell (x,y); static during INIT
- pellet_map  in  MAZE_W*MAZE_H  1 = power pellet, same indexing
- ready  out  1  1 in RUN state
- query_x / query_y  in  XW / YW  cell query
- is_wall, has_dot, has_pellet  out  1 each  combinational query results
- eat_req  in  1  eat request, one cycle
- eat_x / eat_y  in  XW / YW  cell to eat
- eat_ack  out  1  one-cycle response pulse
- eat_type  out  2  00 none, 01 dot, 10 pellet; valid with eat_ack
- frame_tick  in  1  one pulse per video frame
- pixel_x / pixel_y  in  PXW  render pixel
- render_wall, render_dot, render_pellet  out  1 each  registered pixel flags
- dots_remaining  out  CNT_W  dots plus pellets left
- all_dots_eaten  out  1  dots_remaining==0 and ready
- level_clear  out  1  one-cycle pulse on the last item eaten

## Operation
- States are INIT and RUN.
- rst or game_reset, in any state, selects INIT with row_ctr=0 and count=0.
- INIT loads one row per cycle for row r=row_ctr:
  - dot_row[r] = ~wall & ~pellet
  - pel_row[r] = pellet & ~wall
  - count += popcount(dot_row[r] | pel_row[r])
- After row MAZE_H-1 is loaded, the block enters RUN and ready becomes 1.
- Queries:
  - Out-of-range cells (x>=MAZE_W or y>=MAZE_H) return is_wall=1, has_dot=0, has_pellet=0.
  - In INIT, has_dot and has_pellet return 0. is_wall always reflects wall_map.
- Eat, sampled only in RUN:
  - Dot present: clear it, eat_type=01, count-1.
  - Pellet present: clear it, eat_type=10, count-1.
  - Otherwise eat_type=00 and count is unchanged.
  - eat_ack pulses for every eat_req, including in INIT, where eat_type=00 and no state changes.
- level_clear pulses when a RUN eat decrements count from 1 to 0.
  - A level with no items does not pulse. It shows all_dots_eaten=1 as soon as ready rises.
- Blink: a counter counts frame_tick pulses. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase. Pellets draw only when blink_phase=0. rst/game_reset clear both the counter and blink_phase.
- Render:
  - cell = pixel / CELL_SIZE and off = pixel % CELL_SIZE on each axis.
  - Dot area: off in [CELL_SIZE/2-1, CELL_SIZE/2] on both axes.
  - Pellet area: off in [CELL_SIZE/2-2, CELL_SIZE/2+1] on both axes.
  - Out-of-range cells render all three flags as 0.
  - render_dot and render_pellet are never 1 on a wall cell.

## Timing
- Reset values, one cycle after rst:
  - ready=0, eat_ack=0, eat_type=00, level_clear=0, dots_remaining=0, all_dots_eaten=0
  - render_wall, render_dot and render_pellet are 0.
- INIT latency: ready rises exactly MAZE_H cycles after the cycle rst/game_reset is deasserted. dots_remaining is final in the same cycle ready rises.
- Eat latency: eat_req in cycle N gives eat_ack, eat_type, the updated bitmap and dots_remaining in cycle N+1. level_clear is also in N+1.
- Back-to-back eat_req every cycle is supported. A repeat on the same cell in cycle N+1 sees the cleared bit and returns 00.
- Query is combinational. It reflects eats whose ack has already been issued.
- Render: registered, one-cycle latency from pixel_x/pixel_y.
- Simultaneous events:
  - game_reset with eat_req: reset wins and eat_ack is 0.
  - frame_tick in INIT is ignored.

## Test plan
- Default 20x15, 5 pellets in open cells, walls as the standard layout. Release rst. Required: ready=0 for 15 cycles, then ready=1 and dots_remaining = open-cell count.
- In RUN, eat_req at dot cell (1,1). Required: next cycle eat_ack=1, eat_type=01, dots_remaining decremented by 1, has_dot(1,1)=0. The same request again returns eat_type=00.
- eat_req on a pellet cell, then on a wall cell (0,0), then on (25,3). Required: types 10, 00, 00. Count drops by 1 only.
- Eat every item, back-to-back one per cycle. Required: a single level_clear pulse on the final ack, and all_dots_eaten=1 from that cycle.
- Assert game_reset mid-level with eat_req high. Required: eat_ack=0, ready low for MAZE_H cycles, full count restored.
- 32 frame_tick pulses. Sweep a pellet cell at pixels (x*10+3..x*10+6). Required: render_pellet=1 only during blink_phase=0, one cycle after the pixel is presented.
